// File: rtl/cfg_readback_tx_pkg.sv
// Shared definitions for the configuration readback transmitter: frame layout,
// serializer state encoding and the b1 flag-byte field positions.
package cfg_readback_tx_pkg;

    localparam int         FRAME_LEN     = 7;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // b1 layout, shared with the register bank and host tooling
    localparam int B1_ENABLE     = 7;
    localparam int B1_NOISE_OFF  = 6;
    localparam int B1_SIGNAL_OFF = 5;
    localparam int B1_NSAT_LSB   = 0;
    localparam int NSAT_W        = 5;

    typedef struct packed {
        logic              enable;
        logic              noise_off;
        logic              signal_off;
        logic [NSAT_W-1:0] n_sat;
        logic [15:0]       ca_phase;
        logic [7:0]        doppler;
        logic [7:0]        snr;
    } cfg_snap_t;

    function automatic logic [7:0] pack_b1(input cfg_snap_t s);
        logic [7:0] b;
        b                             = '0;
        b[B1_ENABLE]                  = s.enable;
        b[B1_NOISE_OFF]               = s.noise_off;
        b[B1_SIGNAL_OFF]              = s.signal_off;
        b[B1_NSAT_LSB +: NSAT_W]      = s.n_sat;
        return b;
    endfunction

endpackage

// File: rtl/cfg_readback_tx_uart_tx_byte.sv
// 8N1 serializer for one byte. A new byte can be chained in the last stop-bit
// cycle so consecutive bytes leave no idle gap.
module uart_tx_byte
    import cfg_readback_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic [7:0] byte_in,
    input  logic       start_in,
    output logic       tx_out,
    output logic       ready_out
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_last;

    assign bit_last  = (bit_cnt == CNT_LAST);
    assign ready_out = (state == ST_IDLE) || (state == ST_STOP && bit_last);

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_out  <= 1'b1;
        end else begin
            bit_cnt <= bit_last ? '0 : bit_cnt + CNT_ONE;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    tx_out  <= 1'b1;
                    if (start_in) begin
                        shreg  <= byte_in;
                        tx_out <= 1'b0;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        bit_idx <= '0;
                        tx_out  <= shreg[0];
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        // shreg[0] is always the bit currently on the line
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx_out <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shreg[1];
                        end
                    end
                end
                default: begin
                    if (bit_last) begin
                        if (start_in) begin
                            shreg  <= byte_in;
                            tx_out <= 1'b0;
                            state  <= ST_START;
                        end else begin
                            state  <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cfg_readback_tx.sv
// Configuration readback: snapshots the register bank on request and sends
// sync, five config bytes and an XOR checksum over a UART tx line.
module cfg_readback_tx
    import cfg_readback_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 142,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        send_in,
    input  logic        enable_in,
    input  logic [4:0]  n_sat_in,
    input  logic        noise_off_in,
    input  logic        signal_off_in,
    input  logic [15:0] ca_phase_in,
    input  logic [7:0]  doppler_in,
    input  logic [7:0]  snr_in,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    cfg_snap_t  snap;
    logic [2:0] byte_idx;
    logic [2:0] next_idx;
    logic [7:0] b1;
    logic [7:0] csum;
    logic [7:0] next_byte;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_ready;

    always_comb begin
        b1       = pack_b1(snap);
        csum     = b1 ^ snap.ca_phase[15:8] ^ snap.ca_phase[7:0] ^ snap.doppler ^ snap.snr;
        next_idx = byte_idx + 3'd1;
        case (next_idx)
            3'd0:    next_byte = SYNC_BYTE;
            3'd1:    next_byte = b1;
            3'd2:    next_byte = snap.ca_phase[15:8];
            3'd3:    next_byte = snap.ca_phase[7:0];
            3'd4:    next_byte = snap.doppler;
            3'd5:    next_byte = snap.snr;
            default: next_byte = csum;
        endcase
        // The sync byte is a constant, so the first start bit can launch in
        // the accept cycle before the snapshot registers have loaded.
        if (!busy_out) begin
            tx_start = send_in;
            tx_byte  = SYNC_BYTE;
        end else begin
            tx_start = tx_ready && (byte_idx != LAST_IDX);
            tx_byte  = next_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            snap     <= '0;
            byte_idx <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (!busy_out) begin
                if (send_in) begin
                    snap     <= '{enable:     enable_in,
                                  noise_off:  noise_off_in,
                                  signal_off: signal_off_in,
                                  n_sat:      n_sat_in,
                                  ca_phase:   ca_phase_in,
                                  doppler:    doppler_in,
                                  snr:        snr_in};
                    byte_idx <= '0;
                    busy_out <= 1'b1;
                end
            end else if (tx_ready) begin
                if (byte_idx != LAST_IDX) begin
                    byte_idx <= next_idx;
                end else begin
                    byte_idx <= '0;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .byte_in   (tx_byte),
        .start_in  (tx_start),
        .tx_out    (tx_out),
        .ready_out (tx_ready)
    );

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Directed bench for cfg_readback_tx: a fast instance (4 clocks/bit) for frame
// content and sequencing, and a default-rate instance for bit timing.
module tb_cfg_readback_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send4, send142;
    logic        enable, noise_off, signal_off;
    logic [4:0]  n_sat;
    logic [15:0] ca_phase;
    logic [7:0]  doppler, snr;
    logic        tx4, busy4, done4;
    logic        tx142, busy142, done142;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_done4 = 0;
    logic [7:0]  rxb [7];
    int          rx_t0;
    int          prev_t0;
    int          done_before;
    int          busy_cnt;
    int          n;
    int          k, j, p;
    logic [55:0] fr;
    logic [7:0]  cur_byte;
    logic        eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done4 === 1'b1) n_done4 <= n_done4 + 1;

    cfg_readback_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk_in(clk), .rst_in_n(rst_n), .send_in(send4),
        .enable_in(enable), .n_sat_in(n_sat), .noise_off_in(noise_off),
        .signal_off_in(signal_off), .ca_phase_in(ca_phase), .doppler_in(doppler),
        .snr_in(snr), .tx_out(tx4), .busy_out(busy4), .done_out(done4)
    );

    cfg_readback_tx dut142 (
        .clk_in(clk), .rst_in_n(rst_n), .send_in(send142),
        .enable_in(enable), .n_sat_in(n_sat), .noise_off_in(noise_off),
        .signal_off_in(signal_off), .ca_phase_in(ca_phase), .doppler_in(doppler),
        .snr_in(snr), .tx_out(tx142), .busy_out(busy142), .done_out(done142)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic en, input logic no, input logic so, input logic [4:0] ns,
                           input logic [15:0] ca, input logic [7:0] dp, input logic [7:0] sr);
        enable = en; noise_off = no; signal_off = so; n_sat = ns;
        ca_phase = ca; doppler = dp; snr = sr;
    endtask

    // Called at a negedge; leaves the bench at the first negedge with tx4 low.
    task automatic pulse4();
        @(negedge clk); send4 = 1'b1;
        @(negedge clk); send4 = 1'b0;
    endtask

    // Decode one frame from tx4, sampling mid-bit; returns mid b6 stop bit.
    task automatic rx_frame();
        int w;
        for (int jj = 0; jj < 7; jj++) begin
            w = 0;
            while (tx4 !== 1'b0 && w < 600) begin @(negedge clk); w++; end
            chk($sformatf("start_seen_b%0d", jj), {31'd0, tx4 === 1'b0}, 32'd1);
            if (jj == 0) rx_t0 = cyc;
            else chk($sformatf("byte_gap_b%0d", jj), cyc - rx_t0, 40 * jj);
            repeat (2) @(negedge clk);
            chk($sformatf("start_bit_b%0d", jj), {31'd0, tx4}, 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (4) @(negedge clk);
                rxb[jj][b] = tx4;
            end
            repeat (4) @(negedge clk);
            chk($sformatf("stop_bit_b%0d", jj), {31'd0, tx4}, 32'd1);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [55:0] exp);
        for (int jj = 0; jj < 7; jj++)
            chk($sformatf("%s_b%0d", tag, jj), {24'd0, rxb[jj]}, {24'd0, exp[55 - 8*jj -: 8]});
    endtask

    initial begin
        rst_n = 1'b0; send4 = 1'b0; send142 = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
        repeat (3) @(negedge clk);
        chk("rst_tx4",    {31'd0, tx4},    32'd1);
        chk("rst_busy4",  {31'd0, busy4},  32'd0);
        chk("rst_done4",  {31'd0, done4},  32'd0);
        chk("rst_tx142",  {31'd0, tx142},  32'd1);
        chk("rst_busy142",{31'd0, busy142},32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with done latency
        set_cfg(1'b1, 1'b0, 1'b1, 5'd3, 16'h1234, 8'h56, 8'h78);
        done_before = n_done4;
        pulse4();
        chk("basic_busy_start", {31'd0, busy4}, 32'd1);
        rx_frame();
        chk_frame("basic", 56'hA5A312345678AB);
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("done_lat", cyc - rx_t0, 32'd280);
        chk("done_busy_low", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done4}, 32'd0);
        chk("basic_done_count", n_done4 - done_before, 32'd1);

        // Default-rate bit timing, same configuration
        fr = 56'hA5A312345678AB;
        @(negedge clk);
        chk("t_idle_before", {31'd0, tx142}, 32'd1);
        send142 = 1'b1;
        @(negedge clk);
        send142 = 1'b0;
        chk("t_start_next_cycle", {31'd0, tx142}, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 9940; i++) begin
            k = i / 142; j = k / 10; p = k % 10;
            cur_byte = fr[55 - 8*j -: 8];
            eb = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : cur_byte[p-1];
            if ((i % 142) == 0 || (i % 142) == 141)
                chk($sformatf("t_bit%0d_off%0d", k, i % 142), {31'd0, tx142}, {31'd0, eb});
            if (busy142 === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk("t_done", {31'd0, done142}, 32'd1);
        chk("t_busy_end", {31'd0, busy142}, 32'd0);
        chk("t_busy_cycles", busy_cnt, 32'd9940);

        // Snapshot and ignore: inputs change and send pulses mid-frame
        set_cfg(1'b0, 1'b1, 1'b0, 5'd5, 16'hABCD, 8'h01, 8'hFE);
        done_before = n_done4;
        pulse4();
        fork
            rx_frame();
            begin
                repeat (60) @(negedge clk);
                set_cfg(1'b1, 1'b0, 1'b1, 5'd31, 16'h0000, 8'hFF, 8'h00);
                send4 = 1'b1;
                @(negedge clk);
                send4 = 1'b0;
            end
        join
        chk_frame("snap", 56'hA545ABCD01FEDC);
        repeat (20) @(negedge clk);
        chk("snap_no_second_busy", {31'd0, busy4}, 32'd0);
        chk("snap_idle_tx", {31'd0, tx4}, 32'd1);
        chk("snap_done_count", n_done4 - done_before, 32'd1);

        // Checksum edge: only n_sat set
        set_cfg(1'b0, 1'b0, 1'b0, 5'd31, 16'h0000, 8'h00, 8'h00);
        pulse4();
        rx_frame();
        chk_frame("csum", 56'hA51F000000001F);
        repeat (10) @(negedge clk);

        // Back-to-back: send held high, snr changes between frames.
        // The done cycle is the only idle-high cycle between frames.
        set_cfg(1'b1, 1'b0, 1'b1, 5'd3, 16'h1234, 8'h56, 8'h11);
        done_before = n_done4;
        send4 = 1'b1;
        rx_frame();
        chk_frame("b2b0", 56'hA5A312345611C2);
        prev_t0 = rx_t0;
        snr = 8'h22;
        rx_frame();
        chk_frame("b2b1", 56'hA5A312345622F1);
        chk("b2b_gap1", rx_t0 - prev_t0, 32'd281);
        prev_t0 = rx_t0;
        snr = 8'h33;
        rx_frame();
        send4 = 1'b0;
        chk_frame("b2b2", 56'hA5A312345633E0);
        chk("b2b_gap2", rx_t0 - prev_t0, 32'd281);
        repeat (20) @(negedge clk);
        chk("b2b_stopped", {31'd0, busy4}, 32'd0);
        chk("b2b_done_count", n_done4 - done_before, 32'd3);

        // Reset during the data bits of b3 (second data bit is a 0)
        set_cfg(1'b1, 1'b0, 1'b1, 5'd3, 16'h1234, 8'h56, 8'h78);
        done_before = n_done4;
        pulse4();
        repeat (130) @(negedge clk);
        chk("pre_rst_tx", {31'd0, tx4}, 32'd0);
        chk("pre_rst_busy", {31'd0, busy4}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", {31'd0, tx4}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy4}, 32'd0);
        chk("mid_rst_done", {31'd0, done4}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst_no_done", n_done4 - done_before, 32'd0);
        chk("rst_idle_tx", {31'd0, tx4}, 32'd1);
        pulse4();
        rx_frame();
        chk_frame("post_rst", 56'hA5A312345678AB);
        repeat (5) @(negedge clk);
        chk("post_rst_done_count", n_done4 - done_before, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
